brew_scheduler: RTL and testbench
=================================

Name: brew_scheduler

Overview:
Shares a single brew unit (heater, grinder, pump) between NREQ paid-order stations, each a coin-acceptor front end.
- Arbitrates pending orders round-robin.
- Sequences the brew phases with per-phase cycle timers.
- Aborts safely on cup removal.
- Counts drinks served.
Sits between the station FSMs and the brew-unit actuator drivers.

Parameters:
NREQ, 2, number of ordering stations (2..4)
HEAT_CYC, 8, heater-on cycles per order (>=1)
GRIND_CYC, 4, grinder-on cycles per order (>=1)
POUR_BASE, 4, pump cycles per size unit; pour length = POUR_BASE*(sel+1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low
req  in  NREQ  per-station order request; held high until granted
sel  in  2*NREQ  per-station drink select, station i at bits [2i+1:2i]; 0 = hot water (no grind), 1..3 = coffee sizes
cup_present  in  1  cup sensor, 1 = cup in place
fault_clr  in  1  operator fault acknowledge
grant  out  NREQ  one-hot, 1-cycle pulse when an order is accepted
busy  out  1  high in any state other than IDLE
heater_on  out  1  heater drive
grinder_on  out  1  grinder drive
pump_on  out  1  pump drive
done  out  1  1-cycle pulse on successful completion
done_id  out  clog2(NREQ)  station index served; valid with done, holds value otherwise
fault  out  1  high while in FAULT
served_cnt  out  8  completed-drink count, wraps 255->0

Behaviour:
- All outputs registered (Moore), updated with state.
- Reset (reset=0 at a clk edge): state=IDLE; every output 0; round-robin pointer selects station 0 first; timer cleared. Reset wins over every other event, including mid-phase. Actuators drop the cycle after the reset edge.
- States: IDLE, HEAT, GRIND, POUR, DONE, FAULT.
- IDLE:
  - If any req bit is high and cup_present=1, pick the first requester at or after the pointer, wrapping.
  - Next cycle: state=HEAT, grant one-hot for exactly 1 cycle. Latch the station's sel and index. Pointer = winner+1 mod NREQ.
  - If req is present but cup_present=0, stay in IDLE with no grant.
- HEAT: heater_on=1 for exactly HEAT_CYC cycles. Then go to GRIND, or to POUR if latched sel=0.
- GRIND: grinder_on=1 for exactly GRIND_CYC cycles, then POUR.
- POUR: pump_on=1 for exactly POUR_BASE*(sel+1) cycles, then DONE.
- Actuator exclusivity: at most one of heater_on, grinder_on, pump_on is high in any cycle.
- DONE: 1 cycle.
  - done=1, done_id=latched index, served_cnt increments (wraps modulo 256).
  - Next state IDLE. The next arbitration happens in IDLE, so a 1-cycle gap between orders is guaranteed.
- Cup removal: cup_present=0 sampled in HEAT, GRIND or POUR forces FAULT on the next cycle.
  - All actuators 0 and fault=1 in that cycle.
  - The order is dropped: no done, served_cnt unchanged, no re-grant of the dropped order.
- FAULT: leave only when fault_clr=1 and cup_present=1 on the same edge, then go to IDLE.
  - fault_clr with no cup: stay in FAULT.
  - req is ignored in FAULT.
- grant/req protocol: a station deasserts req after its grant. A req still high afterwards counts as a new order. req dropped before grant is simply not served.
- sel is sampled only on the arbitration edge; later changes are ignored.
- Timer: single down-counter sized for max(HEAT_CYC, GRIND_CYC, 4*POUR_BASE). Loaded on phase entry; phase exits when it reaches 1.

Decomposition:
- brew_pkg holds:
  - state enum
  - sel encoding constants (SEL_WATER=0)
  - timer width function
  - counter width constant (8)
- One sub-module, phase_timer: load value, load strobe, count enable, expire flag. Instantiated once.
- Arbitration stays inline.

Test Plan:
1. reset=0 for 3 cycles with req=2'b11, cup_present=1 -> grant, busy and all actuators 0; served_cnt=0; first grant after release is to station 0.
2. (NREQ=2, HEAT_CYC=3, GRIND_CYC=2, POUR_BASE=2) req=01, sel0=1 -> grant=01 for 1 cycle; heater 3 cycles, grinder 2, pump 4; then done=1 with done_id=0; served_cnt=1; busy for 10 cycles total.
3. req=11 held continuously, sel=2'b01 for both -> grants alternate 01,10,01,10; done_id alternates 0,1,0,1; never two actuators high together.
4. sel0=0 (hot water) -> grinder_on never asserts; heater 3 cycles then pump 2 cycles; done pulse.
5. cup_present dropped in 2nd pump cycle -> next cycle fault=1, pump_on=0, no done, served_cnt unchanged. fault_clr=1 with cup=0 -> stays in FAULT. fault_clr=1 with cup=1 -> IDLE, fault=0.
6. 256 consecutive completions -> served_cnt wraps 255->0. Separately, reset=0 mid-GRIND -> next cycle all outputs 0, state IDLE, pointer back to station 0.

Source files
------------

// File: rtl/brew_pkg.sv
// -----------------------------------------------------------------------------
// brew_pkg
//   Shared types and constants for the brew-unit scheduler.
//   - state_t      : scheduler FSM states
//   - SEL_WATER    : drink-select code for hot water (grinder skipped)
//   - CNT_W        : width of the served-drink counter
//   - timer_width(): bits needed by the phase timer to hold the longest phase
// -----------------------------------------------------------------------------
package brew_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HEAT  = 3'd1,
        S_GRIND = 3'd2,
        S_POUR  = 3'd3,
        S_DONE  = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    localparam logic [1:0] SEL_WATER = 2'd0;
    localparam int         CNT_W     = 8;

    // Longest phase is max(heat, grind, largest pour = 4 size units).
    function automatic int timer_width(input int heat_cyc, input int grind_cyc,
                                       input int pour_base);
        int longest;
        longest = heat_cyc;
        if (grind_cyc > longest)     longest = grind_cyc;
        if (4 * pour_base > longest) longest = 4 * pour_base;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/brew_scheduler_phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
//   Down-counter timing one brew phase. Loaded with the phase length on phase
//   entry; expire is high while the count sits at 1, i.e. during the last
//   cycle of the phase.
//   Ports:
//     clk, reset   clock, synchronous active-low reset
//     load         load strobe (wins over en)
//     load_val     phase length in cycles
//     en           count enable (decrements while above zero)
//     expire       last cycle of the current phase
// -----------------------------------------------------------------------------
module phase_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expire
);

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    // NOTE: reset is sampled on the clock edge (synchronous), so it only lives
    // inside the clocked block and never appears in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expire = (count == W'(1));

endmodule

// File: rtl/brew_scheduler.sv
// -----------------------------------------------------------------------------
// brew_scheduler
//   Shares one brew unit (heater, grinder, pump) between NREQ ordering
//   stations. Orders are arbitrated round-robin in IDLE, then sequenced
//   HEAT -> GRIND (skipped for hot water) -> POUR -> DONE. Losing the cup in
//   any actuator phase drops the order and parks the unit in FAULT until the
//   operator clears it with the cup back in place. All outputs are registered
//   and change together with the state.
//   Ports:
//     clk, reset    clock, synchronous active-low reset
//     req[NREQ]     per-station order request, held until granted
//     sel[2*NREQ]   per-station drink select (0 = hot water, 1..3 = sizes)
//     cup_present   cup sensor
//     fault_clr     operator fault acknowledge
//     grant         one-hot acceptance pulse
//     busy          not IDLE
//     heater_on, grinder_on, pump_on   actuator drives (mutually exclusive)
//     done, done_id completion pulse and station served (done_id holds)
//     fault         unit parked in FAULT
//     served_cnt    completed drinks, wraps
// -----------------------------------------------------------------------------
module brew_scheduler
    import brew_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int HEAT_CYC  = 8,
    parameter int GRIND_CYC = 4,
    parameter int POUR_BASE = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [2*NREQ-1:0]        sel,
    input  logic                     cup_present,
    input  logic                     fault_clr,
    output logic [NREQ-1:0]          grant,
    output logic                     busy,
    output logic                     heater_on,
    output logic                     grinder_on,
    output logic                     pump_on,
    output logic                     done,
    output logic [$clog2(NREQ)-1:0]  done_id,
    output logic                     fault,
    output logic [CNT_W-1:0]         served_cnt
);

    localparam int IDW = $clog2(NREQ);
    localparam int TW  = timer_width(HEAT_CYC, GRIND_CYC, POUR_BASE);

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [1:0]       sel_q, sel_d;
    logic [NREQ-1:0]  grant_d;

    logic [1:0]       sel_arr [NREQ];
    logic             found;
    logic [IDW-1:0]   win;
    logic [IDW-1:0]   idx;

    logic             tmr_load, tmr_en, tmr_expire;
    logic [TW-1:0]    tmr_val;

    for (genvar i = 0; i < NREQ; i++) begin : g_sel
        assign sel_arr[i] = sel[2*i +: 2];
    end

    // Round-robin pick: first requester at or after the pointer, wrapping.
    // NOTE: every signal written in a combinational block gets a default at
    // the top, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(ptr_q) + k) % NREQ);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        grant_d = '0;
        ptr_d   = ptr_q;
        id_d    = id_q;
        sel_d   = sel_q;
        case (state_q)
            S_IDLE: begin
                if (found && cup_present) begin
                    state_d = S_HEAT;
                    grant_d = NREQ'(1) << win;
                    ptr_d   = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
                    id_d    = win;
                    sel_d   = sel_arr[win];
                end
            end
            S_HEAT: begin
                if (!cup_present)    state_d = S_FAULT;
                else if (tmr_expire) state_d = (sel_q == SEL_WATER) ? S_POUR : S_GRIND;
            end
            S_GRIND: begin
                if (!cup_present)    state_d = S_FAULT;
                else if (tmr_expire) state_d = S_POUR;
            end
            S_POUR: begin
                if (!cup_present)    state_d = S_FAULT;
                else if (tmr_expire) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            S_FAULT: if (fault_clr && cup_present) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Timer is reloaded whenever a timed phase is entered; cup-loss exits
    // leave it running, which is harmless since the next entry reloads it.
    always_comb begin
        tmr_en   = (state_q == S_HEAT) || (state_q == S_GRIND) || (state_q == S_POUR);
        tmr_load = (state_d != state_q);
        tmr_val  = '0;
        case (state_d)
            S_HEAT:  tmr_val = TW'(HEAT_CYC);
            S_GRIND: tmr_val = TW'(GRIND_CYC);
            S_POUR:  tmr_val = TW'(POUR_BASE * (int'(sel_d) + 1));
            default: tmr_load = 1'b0;
        endcase
    end

    phase_timer #(.W(TW)) u_phase_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .expire   (tmr_expire)
    );

    // State plus Moore outputs, all derived from the next state so they
    // change on the same edge as the state itself.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            id_q       <= '0;
            sel_q      <= '0;
            grant      <= '0;
            busy       <= 1'b0;
            heater_on  <= 1'b0;
            grinder_on <= 1'b0;
            pump_on    <= 1'b0;
            done       <= 1'b0;
            done_id    <= '0;
            fault      <= 1'b0;
            served_cnt <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            sel_q      <= sel_d;
            grant      <= grant_d;
            busy       <= (state_d != S_IDLE);
            heater_on  <= (state_d == S_HEAT);
            grinder_on <= (state_d == S_GRIND);
            pump_on    <= (state_d == S_POUR);
            done       <= (state_d == S_DONE);
            fault      <= (state_d == S_FAULT);
            if (state_d == S_DONE) begin
                done_id    <= id_q;
                served_cnt <= served_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_brew_scheduler.sv
// -----------------------------------------------------------------------------
// tb_brew_scheduler
//   Self-checking bench for brew_scheduler (NREQ=2, HEAT=3, GRIND=2,
//   POUR_BASE=2). A schedule-based reference model expands each accepted
//   order into its list of expected cycles; every cycle all outputs are
//   compared against the model, and each scenario task adds its own
//   directed checks.
// -----------------------------------------------------------------------------
module tb_brew_scheduler;

    localparam int NREQ  = 2;
    localparam int HEAT  = 3;
    localparam int GRIND = 2;
    localparam int PB    = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [3:0]  sel = 4'h0;
    logic        cup_present = 1'b1;
    logic        fault_clr = 1'b0;

    logic [1:0]  grant;
    logic        busy, heater_on, grinder_on, pump_on, done, fault;
    logic [0:0]  done_id;
    logic [7:0]  served_cnt;

    always #5 clk = ~clk;

    brew_scheduler #(
        .NREQ(NREQ), .HEAT_CYC(HEAT), .GRIND_CYC(GRIND), .POUR_BASE(PB)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req        (req),
        .sel        (sel),
        .cup_present(cup_present),
        .fault_clr  (fault_clr),
        .grant      (grant),
        .busy       (busy),
        .heater_on  (heater_on),
        .grinder_on (grinder_on),
        .pump_on    (pump_on),
        .done       (done),
        .done_id    (done_id),
        .fault      (fault),
        .served_cnt (served_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model ----------------
    typedef enum int {K_IDLE, K_HEAT, K_GRIND, K_POUR, K_DONE, K_FAULT} kind_e;
    typedef struct {
        kind_e kind;
        bit    gnt;
        int    id;
    } cyc_t;

    cyc_t cur;
    cyc_t sched[$];
    int   m_ptr = 0;
    int   m_served = 0;
    int   m_done_id = 0;
    bit   auto_drop = 1'b1;

    function automatic cyc_t mk(kind_e k, bit g, int id);
        cyc_t c;
        c.kind = k;
        c.gnt  = g;
        c.id   = id;
        return c;
    endfunction

    // One clock edge of the model, using the inputs seen at that edge.
    task automatic model_step();
        if (!reset) begin
            sched.delete();
            cur       = mk(K_IDLE, 1'b0, 0);
            m_ptr     = 0;
            m_served  = 0;
            m_done_id = 0;
        end else if (cur.kind == K_FAULT) begin
            if (fault_clr && cup_present) cur = mk(K_IDLE, 1'b0, 0);
        end else if ((cur.kind == K_HEAT || cur.kind == K_GRIND || cur.kind == K_POUR)
                     && !cup_present) begin
            sched.delete();
            cur = mk(K_FAULT, 1'b0, 0);
        end else if (sched.size() != 0) begin
            cur = sched.pop_front();
            if (cur.kind == K_DONE) begin
                m_served  = (m_served + 1) % 256;
                m_done_id = cur.id;
            end
        end else if (cur.kind == K_DONE) begin
            cur = mk(K_IDLE, 1'b0, 0);
        end else if (req != 2'b00 && cup_present) begin
            int w;
            int s;
            w = -1;
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (m_ptr + k) % NREQ;
                if (w < 0 && ((req >> j) & 2'b01) != 2'b00) w = j;
            end
            s     = int'(2'(sel >> (2 * w)));
            m_ptr = (w + 1) % NREQ;
            for (int i = 0; i < HEAT; i++) sched.push_back(mk(K_HEAT, i == 0, w));
            if (s != 0)
                for (int i = 0; i < GRIND; i++) sched.push_back(mk(K_GRIND, 1'b0, w));
            for (int i = 0; i < PB * (s + 1); i++) sched.push_back(mk(K_POUR, 1'b0, w));
            sched.push_back(mk(K_DONE, 1'b0, w));
            cur = sched.pop_front();
        end
    endtask

    // Advance one cycle, then compare every output with the model.
    task automatic tick();
        logic [1:0]  eg;
        logic [16:0] exp_v, act_v;
        @(posedge clk);
        model_step();
        @(negedge clk);
        eg    = cur.gnt ? 2'(2'b01 << cur.id) : 2'b00;
        exp_v = {eg, cur.kind != K_IDLE, cur.kind == K_HEAT, cur.kind == K_GRIND,
                 cur.kind == K_POUR, cur.kind == K_DONE, 1'(m_done_id),
                 cur.kind == K_FAULT, 8'(m_served)};
        act_v = {grant, busy, heater_on, grinder_on, pump_on, done, done_id,
                 fault, served_cnt};
        n_checks++;
        if (act_v !== exp_v) begin
            n_fail++;
            $display("FAIL outputs t=%0t got %h expected %h (grant,busy,heat,grind,pump,done,id,fault,cnt)",
                     $time, act_v, exp_v);
        end
        n_checks++;
        if ($countones({heater_on, grinder_on, pump_on}) > 1) begin
            n_fail++;
            $display("FAIL actuator_exclusive t=%0t got %b%b%b expected at most one high",
                     $time, heater_on, grinder_on, pump_on);
        end
        if (auto_drop) req = req & ~grant;
    endtask

    // Return to IDLE with nothing pending.
    task automatic drain();
        req         = 2'b00;
        cup_present = 1'b1;
        fault_clr   = 1'b1;
        for (int i = 0; i < 100 && !(cur.kind == K_IDLE && sched.size() == 0); i++) tick();
        fault_clr = 1'b0;
        tick();
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0; req = 2'b11; sel = 4'b0101; cup_present = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({grant, busy, heater_on, grinder_on, pump_on} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got %b expected 000000",
                     {grant, busy, heater_on, grinder_on, pump_on});
        end
        n_checks++;
        if (served_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_served got %0d expected 0", served_cnt);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if (grant !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_first_grant got %b expected 01", grant);
        end
        drain();
    endtask

    task automatic test_single_order();
        int h = 0, g = 0, p = 0, b = 0, gc = 0, dc = 0;
        logic [1:0] gv = 2'b00;
        logic [0:0] did = 1'b1;
        int s0;
        s0  = m_served;
        req = 2'b01; sel = 4'b0001;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (heater_on)  h++;
            if (grinder_on) g++;
            if (pump_on)    p++;
            if (busy)       b++;
            if (grant != 2'b00) begin gc++; gv = grant; end
            if (done) begin dc++; did = done_id; end
        end
        n_checks++;
        if (gc != 1 || gv !== 2'b01) begin
            n_fail++;
            $display("FAIL single_grant got %0d pulses value %b expected 1 pulse 01", gc, gv);
        end
        n_checks++;
        if (h != 3 || g != 2 || p != 4) begin
            n_fail++;
            $display("FAIL single_phases got heat %0d grind %0d pump %0d expected 3 2 4", h, g, p);
        end
        n_checks++;
        if (b != 10) begin
            n_fail++;
            $display("FAIL single_busy got %0d expected 10", b);
        end
        n_checks++;
        if (dc != 1 || did !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done got %0d pulses id %0d expected 1 pulse id 0", dc, did);
        end
        n_checks++;
        if (served_cnt !== 8'(s0 + 1)) begin
            n_fail++;
            $display("FAIL single_served got %0d expected %0d", served_cnt, s0 + 1);
        end
        drain();
    endtask

    task automatic test_round_robin();
        logic [1:0] gq[$];
        logic [0:0] dq[$];
        logic [1:0] exp_g[4];
        logic [0:0] exp_d[4];
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_d = '{1'b0, 1'b1, 1'b0, 1'b1};
        reset = 1'b0; tick(); reset = 1'b1;
        auto_drop = 1'b0; req = 2'b11; sel = 4'b0101;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (grant != 2'b00) gq.push_back(grant);
            if (done) dq.push_back(done_id);
        end
        auto_drop = 1'b1;
        n_checks++;
        if (gq.size() < 4 || dq.size() < 4) begin
            n_fail++;
            $display("FAIL rr_count got %0d grants %0d dones expected at least 4 each",
                     gq.size(), dq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (gq[i] !== exp_g[i] || dq[i] !== exp_d[i]) begin
                    n_fail++;
                    $display("FAIL rr_order[%0d] got grant %b id %0d expected grant %b id %0d",
                             i, gq[i], dq[i], exp_g[i], exp_d[i]);
                end
            end
        end
        drain();
    endtask

    task automatic test_hot_water();
        int h = 0, g = 0, p = 0, dc = 0;
        req = 2'b01; sel = 4'b1100;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (heater_on)  h++;
            if (grinder_on) g++;
            if (pump_on)    p++;
            if (done)       dc++;
        end
        n_checks++;
        if (g != 0 || h != 3 || p != 2 || dc != 1) begin
            n_fail++;
            $display("FAIL hot_water got heat %0d grind %0d pump %0d done %0d expected 3 0 2 1",
                     h, g, p, dc);
        end
        drain();
    endtask

    task automatic test_cup_removal();
        int s0;
        int gc = 0;
        s0  = m_served;
        req = 2'b01; sel = 4'b0001;
        for (int i = 0; i < 20 && !pump_on; i++) tick();
        n_checks++;
        if (pump_on !== 1'b1) begin
            n_fail++;
            $display("FAIL cup_pump_start got %b expected 1 within 20 cycles", pump_on);
        end
        tick();                        // second pump cycle
        cup_present = 1'b0;
        tick();
        n_checks++;
        if (fault !== 1'b1 || pump_on !== 1'b0 || done !== 1'b0 || served_cnt !== 8'(s0)) begin
            n_fail++;
            $display("FAIL cup_abort got fault %b pump %b done %b cnt %0d expected 1 0 0 %0d",
                     fault, pump_on, done, served_cnt, s0);
        end
        fault_clr = 1'b1;
        tick();
        n_checks++;
        if (fault !== 1'b1) begin
            n_fail++;
            $display("FAIL cup_clr_no_cup got fault %b expected 1", fault);
        end
        cup_present = 1'b1;
        tick();
        n_checks++;
        if (fault !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL cup_clr got fault %b busy %b expected 0 0", fault, busy);
        end
        fault_clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (grant != 2'b00) gc++;
        end
        n_checks++;
        if (gc != 0) begin
            n_fail++;
            $display("FAIL cup_no_regrant got %0d grants expected 0", gc);
        end
        drain();
    endtask

    task automatic test_wrap();
        int nd = 0;
        logic [7:0] at255 = 8'h00, at256 = 8'hff;
        reset = 1'b0; tick(); reset = 1'b1;
        auto_drop = 1'b0; req = 2'b11; sel = 4'b0000;
        for (int i = 0; i < 256 * 7 + 50 && nd < 256; i++) begin
            tick();
            if (done) begin
                nd++;
                if (nd == 255) at255 = served_cnt;
                if (nd == 256) at256 = served_cnt;
            end
        end
        auto_drop = 1'b1;
        n_checks++;
        if (nd != 256) begin
            n_fail++;
            $display("FAIL wrap_count got %0d completions expected 256", nd);
        end
        n_checks++;
        if (at255 !== 8'd255 || at256 !== 8'd0) begin
            n_fail++;
            $display("FAIL wrap_value got %0d then %0d expected 255 then 0", at255, at256);
        end
        drain();
    endtask

    task automatic test_reset_mid_grind();
        req = 2'b01; sel = 4'b0001;
        for (int i = 0; i < 20 && !grinder_on; i++) tick();
        n_checks++;
        if (grinder_on !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_grind_start got %b expected 1 within 20 cycles", grinder_on);
        end
        reset = 1'b0;
        tick();
        n_checks++;
        if ({grant, busy, heater_on, grinder_on, pump_on, done, done_id, fault, served_cnt} !== 17'b0) begin
            n_fail++;
            $display("FAIL mid_grind_reset got %h expected 0",
                     {grant, busy, heater_on, grinder_on, pump_on, done, done_id, fault, served_cnt});
        end
        reset = 1'b1; req = 2'b11;
        tick();
        n_checks++;
        if (grant !== 2'b01) begin
            n_fail++;
            $display("FAIL mid_grind_ptr got %b expected 01", grant);
        end
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (((req >> i) & 2'b01) == 2'b00) begin
                    if ($urandom_range(0, 7) == 0) req = req | 2'(2'b01 << i);
                end else if ($urandom_range(0, 63) == 0) begin
                    req = req & ~2'(2'b01 << i);
                end
            end
            sel = 4'($urandom);
            if (cup_present) cup_present = ($urandom_range(0, 59) != 0);
            else             cup_present = ($urandom_range(0, 3) == 0);
            fault_clr = ($urandom_range(0, 3) == 0);
            reset     = ($urandom_range(0, 499) != 0);
            tick();
        end
        reset = 1'b1;
        drain();
    endtask

    initial begin
        cur = mk(K_IDLE, 1'b0, 0);
        test_reset();
        test_single_order();
        test_round_robin();
        test_hot_water();
        test_cup_removal();
        test_wrap();
        test_reset_mid_grind();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
